// File: rtl/isi_fir_channel.sv
// ISI channel model: streams signed PAM-4 samples through an L-tap FIR
// with double-buffered taps, round-half-up and output saturation.
module isi_fir_channel #(
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int PULSE_RESPONSE_LENGTH = 4,
  parameter int COEF_WIDTH            = 8,
  parameter int COEF_FRAC             = 6
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0]      signal_in,
  input  logic                                     signal_in_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0]      signal_out,
  output logic                                     signal_out_valid,
  input  logic                                     coef_wr_en,
  input  logic [$clog2(PULSE_RESPONSE_LENGTH)-1:0] coef_addr,
  input  logic signed [COEF_WIDTH-1:0]             coef_data,
  input  logic                                     coef_commit,
  input  logic                                     flush,
  input  logic                                     sat_clear,
  output logic                                     sat_flag
);

  localparam int SR  = SIGNAL_RESOLUTION;
  localparam int L   = PULSE_RESPONSE_LENGTH;
  localparam int CW  = COEF_WIDTH;
  localparam int CF  = COEF_FRAC;
  localparam int PW  = SR + CW;
  localparam int ACW = PW + $clog2(L);

  localparam logic signed [CW-1:0] TAP_ONE  = CW'(2 ** CF);
  localparam logic signed [CW-1:0] TAP_HALF = CW'(2 ** (CF - 1));

  localparam logic signed [ACW-1:0] RND  = ACW'(2 ** (CF - 1));
  localparam logic signed [ACW-1:0] AMAX = ACW'(2 ** (SR - 1) - 1);
  localparam logic signed [ACW-1:0] AMIN = ACW'(-(2 ** (SR - 1)));

  localparam logic signed [SR-1:0] OMAX = {1'b0, {(SR-1){1'b1}}};
  localparam logic signed [SR-1:0] OMIN = {1'b1, {(SR-1){1'b0}}};

  logic signed [CW-1:0]  shd  [L];
  logic signed [CW-1:0]  act  [L];
  logic signed [SR-1:0]  x    [L];
  logic signed [PW-1:0]  prod [L];
  logic                  v0;
  logic                  v1;

  logic signed [ACW-1:0] acc;
  logic signed [ACW-1:0] rnd;
  logic signed [ACW-1:0] shifted;
  logic                  sat_hi;
  logic                  sat_lo;
  logic signed [SR-1:0]  result;

  // Commit reads shadow before this edge's write lands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < L; k++) begin
        if (k == 0) begin
          shd[k] <= TAP_ONE;
          act[k] <= TAP_ONE;
        end else if (k == 1) begin
          shd[k] <= TAP_HALF;
          act[k] <= TAP_HALF;
        end else begin
          shd[k] <= '0;
          act[k] <= '0;
        end
      end
    end else begin
      if (coef_commit) begin
        for (int k = 0; k < L; k++)
          act[k] <= shd[k];
      end
      if (coef_wr_en && (int'(coef_addr) < L))
        shd[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < L; k++)
        x[k] <= '0;
    end else if (signal_in_valid) begin
      x[0] <= signal_in;
      for (int k = 1; k < L; k++)
        x[k] <= flush ? '0 : x[k-1];
    end else if (flush) begin
      for (int k = 0; k < L; k++)
        x[k] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      for (int k = 0; k < L; k++)
        prod[k] <= '0;
    end else begin
      v0 <= signal_in_valid;
      v1 <= v0;
      if (v0) begin
        for (int k = 0; k < L; k++)
          prod[k] <= PW'(x[k]) * PW'(act[k]);
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < L; k++)
      acc = acc + {{(ACW-PW){prod[k][PW-1]}}, prod[k]};
    rnd     = acc + RND;
    shifted = rnd >>> CF;
    sat_hi  = shifted > AMAX;
    sat_lo  = shifted < AMIN;
    unique case (1'b1)
      sat_hi:  result = OMAX;
      sat_lo:  result = OMIN;
      default: result = shifted[SR-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      signal_out       <= '0;
      signal_out_valid <= 1'b0;
      sat_flag         <= 1'b0;
    end else begin
      signal_out_valid <= v1;
      if (v1)
        signal_out <= result;
      if (v1 && (sat_hi || sat_lo))
        sat_flag <= 1'b1;
      else if (sat_clear)
        sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_isi_fir_channel.sv
// Scoreboard bench for isi_fir_channel: a plain-arithmetic convolution
// model predicts each output; a negedge monitor checks the DUT stream.
module tb_isi_fir_channel;

  localparam int SR = 8;
  localparam int L  = 4;
  localparam int CW = 8;
  localparam int CF = 6;
  localparam int AW = $clog2(L);

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic signed [SR-1:0] signal_in = '0;
  logic                 signal_in_valid = 1'b0;
  logic signed [SR-1:0] signal_out;
  logic                 signal_out_valid;
  logic                 coef_wr_en = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic                 coef_commit = 1'b0;
  logic                 flush = 1'b0;
  logic                 sat_clear = 1'b0;
  logic                 sat_flag;

  isi_fir_channel #(
    .SIGNAL_RESOLUTION(SR),
    .PULSE_RESPONSE_LENGTH(L),
    .COEF_WIDTH(CW),
    .COEF_FRAC(CF)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .signal_in(signal_in),
    .signal_in_valid(signal_in_valid),
    .signal_out(signal_out),
    .signal_out_valid(signal_out_valid),
    .coef_wr_en(coef_wr_en),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_commit(coef_commit),
    .flush(flush),
    .sat_clear(sat_clear),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit sat;
    int acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   hist[L];
  int   act[L];
  int   shd[L];
  int   cyc = 0;
  bit   clr_edge = 1'b0;
  bit   rst_edge = 1'b1;
  bit   exp_sat = 1'b0;
  int   last_out = 0;
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string name, input int got, input int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < L; k++) begin
      hist[k] = 0;
      act[k]  = (k == 0) ? 2 ** CF : (k == 1) ? 2 ** (CF - 1) : 0;
      shd[k]  = act[k];
    end
    exp_q.delete();
  endtask

  task automatic predict(input int e);
    int   acc;
    int   r;
    exp_t t;
    acc = 0;
    for (int k = 0; k < L; k++)
      acc += hist[k] * act[k];
    r = (acc + 2 ** (CF - 1)) >>> CF;
    t.sat = 1'b0;
    if (r > 2 ** (SR - 1) - 1) begin
      r = 2 ** (SR - 1) - 1;
      t.sat = 1'b1;
    end else if (r < -(2 ** (SR - 1))) begin
      r = -(2 ** (SR - 1));
      t.sat = 1'b1;
    end
    t.val = r;
    t.acc_edge = e;
    exp_q.push_back(t);
  endtask

  task automatic step(input bit v, input int d, input bit wr,
                      input int a, input int cd, input bit cm,
                      input bit fl, input bit clr);
    signal_in_valid = v;
    signal_in       = SR'(d);
    coef_wr_en      = wr;
    coef_addr       = AW'(a);
    coef_data       = CW'(cd);
    coef_commit     = cm;
    flush           = fl;
    sat_clear       = clr;
    @(posedge clk);
    clr_edge = clr;
    rst_edge = !rstn;
    if (!rstn) begin
      model_reset();
    end else begin
      if (cm)
        for (int k = 0; k < L; k++) act[k] = shd[k];
      if (wr && a < L)
        shd[a] = cd;
      if (fl)
        for (int k = 0; k < L; k++) hist[k] = 0;
      if (v) begin
        for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
        predict(cyc);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic send(input int d);
    step(1, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_flush();
    step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   sat_now;
    if (rst_edge) begin
      chk("reset_valid", int'(signal_out_valid), 0);
      chk("reset_out", int'(signal_out), 0);
      exp_sat  = 1'b0;
      last_out = 0;
    end else begin
      sat_now = 1'b0;
      if (signal_out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_value", int'(signal_out), e.val);
          chk("latency", cyc - 1 - e.acc_edge, 2);
          sat_now  = e.sat;
          last_out = e.val;
        end
      end else begin
        chk("out_hold", int'(signal_out), last_out);
      end
      if (sat_now)
        exp_sat = 1'b1;
      else if (clr_edge)
        exp_sat = 1'b0;
    end
    chk("sat_flag", int'(sat_flag), int'(exp_sat));
  end

  initial begin
    model_reset();
    do_reset(2);

    send(28); send(28); send(28);
    idle(3); do_flush();
    send(-84); send(-84);
    idle(3); do_flush();
    send(27); send(0);
    idle(3); do_flush();
    send(-27); send(0);
    idle(3); do_flush();

    step(0, 0, 1, 1, 64, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    send(84); send(84);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    step(0, 0, 1, 1, 32, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    send(28); idle(3); send(28);
    idle(3); do_flush();

    for (int i = 0; i < 4; i++) send(84);
    step(1, 84, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(84);
    step(1, 84, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) send(84);
    step(1, 28, 0, 0, 0, 0, 1, 0);
    idle(3);

    send(-84); send(-84);
    do_reset(1);
    idle(3);
    send(28); send(28);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      bit v, wr, cm, fl, clr;
      v   = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 5) == 0);
      cm  = ($urandom_range(0, 11) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 9) == 0);
      step(v, int'($urandom_range(0, 255)) - 128, wr,
           int'($urandom_range(0, L - 1)),
           int'($urandom_range(0, 255)) - 128, cm, fl, clr);
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
